// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the two-source round-robin mux arbiter.
//   arb_state_e : arbiter ownership state (IDLE, SERVE_A, SERVE_B)
//   SEL_A/SEL_B : mux select encodings
//   STAT_W      : width of the optional transfer counters
package mux_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_A = 2'd1,
    SERVE_B = 2'd2
  } arb_state_e;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  localparam int unsigned STAT_W = 16;

endpackage

// File: rtl/mux_assign.sv
// Plain 2:1 datapath mux.
//   in_A, in_B : data inputs
//   sel        : 0 selects in_A, 1 selects in_B
//   out        : selected word
module mux_assign #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] in_A,
  input  logic [WIDTH-1:0] in_B,
  input  logic             sel,
  output logic [WIDTH-1:0] out
);

  assign out = sel ? in_B : in_A;

endmodule

// File: rtl/mux_rr_arbiter.sv
// Two-requester round-robin arbiter sharing a 2:1 mux between sources A and B.
// The granted word is registered into a one-entry valid/ready output stage.
// The current owner may keep the mux for up to BURST_MAX beats while the
// other source waits.
//
// Ports:
//   clk, rst_n             : clock, asynchronous active-low reset
//   a_valid/a_data/a_ready : source A channel
//   b_valid/b_data/b_ready : source B channel
//   out_valid/out_data     : registered output word, out_ready from downstream
//   sel                    : current mux select (0 = A, 1 = B)
// Optional (macro MUX_ARB_STATS_EN):
//   stats_clr              : synchronous clear of both transfer counters
//   cnt_a, cnt_b           : saturating per-source transfer counters
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned BURST_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_valid,
  input  logic [WIDTH-1:0]  a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [WIDTH-1:0]  b_data,
  output logic              b_ready,
  output logic              out_valid,
  output logic [WIDTH-1:0]  out_data,
  input  logic              out_ready,
`ifdef MUX_ARB_STATS_EN
  input  logic              stats_clr,
  output logic [STAT_W-1:0] cnt_a,
  output logic [STAT_W-1:0] cnt_b,
`endif
  output logic              sel
);

  localparam int unsigned CntW = $clog2(BURST_MAX + 1);
  localparam logic [CntW-1:0] BurstMax = CntW'(BURST_MAX);

  arb_state_e      r_state, w_state_nxt;
  logic            r_prio, w_prio_nxt;
  logic            r_sel;
  logic [CntW-1:0] r_burst_cnt, w_burst_nxt, w_burst_inc;
  logic            r_out_valid;
  logic [WIDTH-1:0] r_out_data;

  logic             w_grant_a, w_grant_b;
  logic             w_below_max;
  logic             w_load_en;
  logic             w_xfer_a, w_xfer_b;
  logic             w_mux_sel;
  logic [WIDTH-1:0] w_mux_out;

  assign w_below_max = (r_burst_cnt < BurstMax);
  assign w_burst_inc = w_below_max ? r_burst_cnt + CntW'(1) : r_burst_cnt;

  // Grant decision.
  always_comb begin
    w_grant_a = 1'b0;
    w_grant_b = 1'b0;
    case (r_state)
      SERVE_A: begin
        if (a_valid && (w_below_max || !b_valid)) w_grant_a = 1'b1;
        else if (b_valid)                         w_grant_b = 1'b1;
      end
      SERVE_B: begin
        if (b_valid && (w_below_max || !a_valid)) w_grant_b = 1'b1;
        else if (a_valid)                         w_grant_a = 1'b1;
      end
      default: begin
        if (r_prio == SEL_A) begin
          if (a_valid)      w_grant_a = 1'b1;
          else if (b_valid) w_grant_b = 1'b1;
        end else begin
          if (b_valid)      w_grant_b = 1'b1;
          else if (a_valid) w_grant_a = 1'b1;
        end
      end
    endcase
  end

  // With no grant the select keeps its last value.
  assign w_mux_sel = w_grant_b ? SEL_B : (w_grant_a ? SEL_A : r_sel);

  // Ready and select are forced low while reset is asserted, since the grant
  // logic alone would otherwise offer a slot during reset.
  assign w_load_en = !r_out_valid || out_ready;
  assign a_ready   = rst_n && w_load_en && w_grant_a;
  assign b_ready   = rst_n && w_load_en && w_grant_b;
  assign sel       = rst_n ? w_mux_sel : SEL_A;
  assign w_xfer_a  = a_valid && a_ready;
  assign w_xfer_b  = b_valid && b_ready;

  mux_assign #(
    .WIDTH (WIDTH)
  ) u_mux (
    .in_A (a_data),
    .in_B (b_data),
    .sel  (w_mux_sel),
    .out  (w_mux_out)
  );

  // Ownership / priority / burst next-state. Under backpressure nothing moves.
  always_comb begin
    w_state_nxt = r_state;
    w_prio_nxt  = r_prio;
    w_burst_nxt = r_burst_cnt;
    if (w_xfer_a) begin
      w_state_nxt = SERVE_A;
      w_prio_nxt  = SEL_B;
      w_burst_nxt = (r_state == SERVE_A) ? w_burst_inc : CntW'(1);
    end else if (w_xfer_b) begin
      w_state_nxt = SERVE_B;
      w_prio_nxt  = SEL_A;
      w_burst_nxt = (r_state == SERVE_B) ? w_burst_inc : CntW'(1);
    end else if (w_load_en && !a_valid && !b_valid) begin
      w_state_nxt = IDLE;
      w_burst_nxt = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_prio      <= SEL_A;
      r_sel       <= SEL_A;
      r_burst_cnt <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_prio      <= w_prio_nxt;
      r_sel       <= w_mux_sel;
      r_burst_cnt <= w_burst_nxt;
      if (w_xfer_a || w_xfer_b) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_mux_out;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

`ifdef MUX_ARB_STATS_EN
  logic [STAT_W-1:0] r_cnt_a, r_cnt_b;

  // Clear wins over a same-cycle increment; counters stick at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt_a <= '0;
      r_cnt_b <= '0;
    end else if (stats_clr) begin
      r_cnt_a <= '0;
      r_cnt_b <= '0;
    end else begin
      if (w_xfer_a && (r_cnt_a != '1)) r_cnt_a <= r_cnt_a + STAT_W'(1);
      if (w_xfer_b && (r_cnt_b != '1)) r_cnt_b <= r_cnt_b + STAT_W'(1);
    end
  end

  assign cnt_a = r_cnt_a;
  assign cnt_b = r_cnt_b;
`endif

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter (BURST_MAX=2). Stats counters are
// exercised when MUX_ARB_STATS_EN is defined.
module tb_mux_rr_arbiter;

  localparam int unsigned WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             a_valid, b_valid;
  logic [WIDTH-1:0] a_data, b_data;
  logic             a_ready, b_ready;
  logic             out_valid, out_ready;
  logic [WIDTH-1:0] out_data;
  logic             sel;
`ifdef MUX_ARB_STATS_EN
  logic             stats_clr;
  logic [15:0]      cnt_a, cnt_b;
`endif

  int total = 0;
  int bad   = 0;

  mux_rr_arbiter #(
    .WIDTH     (WIDTH),
    .BURST_MAX (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a_valid   (a_valid),
    .a_data    (a_data),
    .a_ready   (a_ready),
    .b_valid   (b_valid),
    .b_data    (b_data),
    .b_ready   (b_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
`ifdef MUX_ARB_STATS_EN
    .stats_clr (stats_clr),
    .cnt_a     (cnt_a),
    .cnt_b     (cnt_b),
`endif
    .sel       (sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int na;
    int nb;
    logic exp_b;
    na = 0;
    nb = 0;

    // Reset held with both sources requesting.
    rst_n     = 1'b0;
    a_valid   = 1'b1;
    b_valid   = 1'b1;
    a_data    = 8'hA0;
    b_data    = 8'hB0;
    out_ready = 1'b1;
`ifdef MUX_ARB_STATS_EN
    stats_clr = 1'b0;
`endif
    #12;
    check("rst_a_ready", a_ready, 0);
    check("rst_b_ready", b_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_sel", sel, 0);

    @(negedge clk);
    rst_n = 1'b1;
    #1;

    // Both valid: A,A,B,B,A,A,B,B with BURST_MAX=2.
    for (int i = 0; i < 8; i++) begin
      exp_b = ((i / 2) % 2) == 1;
      check($sformatf("alt%0d_a_ready", i), a_ready, !exp_b);
      check($sformatf("alt%0d_b_ready", i), b_ready, exp_b);
      check($sformatf("alt%0d_sel", i), sel, exp_b);
      tick();
      check($sformatf("alt%0d_valid", i), out_valid, 1);
      if (exp_b) begin
        check($sformatf("alt%0d_data", i), out_data, 8'hB0 + nb);
        nb++;
        b_data = 8'hB0 + nb[7:0];
      end else begin
        check($sformatf("alt%0d_data", i), out_data, 8'hA0 + na);
        na++;
        a_data = 8'hA0 + na[7:0];
      end
      #1;
    end

    // A-only back-to-back stream 0x01..0x06.
    b_valid = 1'b0;
    a_data  = 8'h01;
    #1;
    for (int i = 1; i <= 6; i++) begin
      check($sformatf("str%0d_a_ready", i), a_ready, 1);
      tick();
      check($sformatf("str%0d_valid", i), out_valid, 1);
      check($sformatf("str%0d_data", i), out_data, i);
      a_data = 8'(i + 1);
      #1;
    end
    a_valid = 1'b0;
    #1;
    check("idle_a_ready", a_ready, 0);
    tick();
    check("drain_valid", out_valid, 0);
    check("idle_sel_hold", sel, 0);

    // Backpressure for 3 cycles after one beat.
    out_ready = 1'b0;
    a_valid   = 1'b1;
    a_data    = 8'h55;
    #1;
    check("bp_first_ready", a_ready, 1);
    tick();
    check("bp_first_data", out_data, 8'h55);
    a_data  = 8'h66;
    b_valid = 1'b1;
    b_data  = 8'h77;
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("bp%0d_a_ready", i), a_ready, 0);
      check($sformatf("bp%0d_b_ready", i), b_ready, 0);
      check($sformatf("bp%0d_valid", i), out_valid, 1);
      check($sformatf("bp%0d_data", i), out_data, 8'h55);
      tick();
    end
    out_ready = 1'b1;
    #1;
    check("resume_a_ready", a_ready, 1);
    check("resume_b_ready", b_ready, 0);
    tick();
    check("resume_data", out_data, 8'h66);
    a_valid = 1'b0;
    #1;
    check("bp_b_ready", b_ready, 1);
    tick();
    check("bp_b_data", out_data, 8'h77);
    b_data = 8'h78;
    #1;
    check("burst2_b_ready", b_ready, 1);
    tick();
    check("burst2_data", out_data, 8'h78);

    // Asynchronous reset between edges during the B burst.
    b_data = 8'h79;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", out_valid, 0);
    check("arst_data", out_data, 0);
    check("arst_sel", sel, 0);
    check("arst_b_ready", b_ready, 0);
    a_valid = 1'b1;
    a_data  = 8'hC1;
    #1;
    rst_n = 1'b1;
    #1;
    check("post_rst_a_ready", a_ready, 1);
    check("post_rst_b_ready", b_ready, 0);
    tick();
    check("post_rst_data", out_data, 8'hC1);
    check("post_rst_valid", out_valid, 1);

`ifdef MUX_ARB_STATS_EN
    check("st_after_rst_a", cnt_a, 1);
    check("st_after_rst_b", cnt_b, 0);
    // Clear in the same cycle as an A transfer.
    b_valid   = 1'b0;
    stats_clr = 1'b1;
    tick();
    stats_clr = 1'b0;
    check("st_clr_prio_a", cnt_a, 0);
    repeat (10) @(posedge clk);
    #1;
    a_valid = 1'b0;
    b_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    b_valid = 1'b0;
    #1;
    check("st_cnt_a", cnt_a, 10);
    check("st_cnt_b", cnt_b, 3);
    stats_clr = 1'b1;
    tick();
    stats_clr = 1'b0;
    check("st_clr_a", cnt_a, 0);
    check("st_clr_b", cnt_b, 0);
    a_valid = 1'b1;
    repeat (65537) @(posedge clk);
    #1;
    a_valid = 1'b0;
    check("st_sat_a", cnt_a, 16'hFFFF);
    check("st_sat_b", cnt_b, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
